// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: round-robin arbiter of CHANNELS sector read/write
// sources onto one sd_rw-style engine. Each grant is handed to the MCU over
// the byte-serial command port for sector translation before the engine starts.
// Optional feature: define SD_TIMEOUT_EN to abort requests left in PENDING
// for TIMEOUT_CYCLES clocks.
module sd_sector_arbiter #(
  parameter int              CHANNELS       = 4,
  parameter int              SECTOR_W       = 32,
  parameter logic [23:0]     TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         data_strobe,
  input  logic                         data_start,
  input  logic [7:0]                   data_in,
  output logic [7:0]                   data_out,
  output logic                         irq,
  input  logic                         iack,
  input  logic [CHANNELS-1:0]          rstart,
  input  logic [CHANNELS-1:0]          wstart,
  input  logic [CHANNELS*SECTOR_W-1:0] sector,
  input  logic [CHANNELS*8-1:0]        ch_inbyte,
  output logic [CHANNELS-1:0]          ch_busy,
  output logic [CHANNELS-1:0]          ch_done,
  output logic [CHANNELS-1:0]          ch_err,
  output logic [CHANNELS-1:0]          ch_outen,
  output logic                         sd_rstart,
  output logic                         sd_wstart,
  output logic [SECTOR_W-1:0]          sd_sector,
  output logic [7:0]                   sd_inbyte,
  input  logic                         sd_outen,
  input  logic                         sd_rbusy,
  input  logic                         sd_rdone
);

  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, XFER = 2'd2, FINISH = 2'd3} state_t;

  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_GO     = 8'h02;
  localparam logic [7:0] CMD_REJECT = 8'h06;

  state_t                state, state_nx;
  logic [1:0]            st_bits;
  logic [CHANNELS-1:0]   rstart_d, wstart_d, pend_r, pend_w;
  logic [CHANNELS-1:0]   gnt_oh, pick_oh, clr_r, clr_w;
  logic [2:0]            grant, last_grant, pick;
  logic                  dir, pick_dir, found, err_flag, go_done;
  logic [SECTOR_W-1:0]   lat_sector, pick_sector;
  logic [7:0]            cmd;
  logic [2:0]            byte_cnt;
  logic                  cmd_stb, dat_stb, any_pend, eng_busy;
  logic                  grant_fire, go_fire, reject_fire, tmo_fire;
  int                    arb_dist, arb_best;

  assign st_bits     = state;
  assign cmd_stb     = data_strobe & data_start;
  assign dat_stb     = data_strobe & ~data_start;
  assign any_pend    = |(pend_r | pend_w);
  assign eng_busy    = sd_rbusy | sd_rstart | sd_wstart;
  assign grant_fire  = (state == IDLE) && found;
  assign go_fire     = dat_stb && (cmd == CMD_GO) && (byte_cnt == 3'd3) && (state == PENDING);
  assign reject_fire = dat_stb && (cmd == CMD_REJECT) && (byte_cnt == 3'd0) && (state == PENDING);

`ifdef SD_TIMEOUT_EN
  logic [23:0] tmo_cnt;

  // PENDING dwell counter, restarted by every grant
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  tmo_cnt <= '0;
    else if (grant_fire)        tmo_cnt <= '0;
    else if (state == PENDING)  tmo_cnt <= tmo_cnt + 24'd1;
  end

  assign tmo_fire = (state == PENDING) && (tmo_cnt == TIMEOUT_CYCLES - 24'd1) && !go_fire;
`else
  // No timeout in this build; the parameter is folded into a constant zero.
  assign tmo_fire = &{1'b0, TIMEOUT_CYCLES};
`endif

  // Round-robin pick: smallest rotational distance after the last grant
  always_comb begin
    found       = 1'b0;
    pick        = '0;
    pick_dir    = 1'b0;
    pick_sector = '0;
    pick_oh     = '0;
    arb_best    = CHANNELS;
    arb_dist    = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      arb_dist = k - int'(last_grant) - 1;
      if (arb_dist < 0) arb_dist = arb_dist + CHANNELS;
      if ((pend_r[k] || pend_w[k]) && (arb_dist < arb_best)) begin
        arb_best    = arb_dist;
        found       = 1'b1;
        pick        = 3'(k);
        pick_dir    = ~pend_r[k];
        pick_sector = sector[k*SECTOR_W +: SECTOR_W];
      end
    end
    for (int k = 0; k < CHANNELS; k++) pick_oh[k] = found && (pick == 3'(k));
    clr_r = (grant_fire && !pick_dir) ? pick_oh : '0;
    clr_w = (grant_fire &&  pick_dir) ? pick_oh : '0;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = PENDING;
      PENDING: if (go_fire) state_nx = XFER;
               else if (reject_fire || tmo_fire) state_nx = FINISH;
      XFER:    if (sd_rdone) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request edge latch; a new edge wins over the grant clearing the same bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rstart_d <= '0;
      wstart_d <= '0;
      pend_r   <= '0;
      pend_w   <= '0;
    end else begin
      rstart_d <= rstart;
      wstart_d <= wstart;
      pend_r   <= (pend_r & ~clr_r) | (rstart & ~rstart_d);
      pend_w   <= (pend_w & ~clr_w) | (wstart & ~wstart_d);
    end
  end

  // Grant context, error flag and MCU interrupt
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant      <= '0;
      last_grant <= 3'(CHANNELS - 1);
      dir        <= 1'b0;
      lat_sector <= '0;
      err_flag   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (grant_fire) begin
        grant      <= pick;
        last_grant <= pick;
        dir        <= pick_dir;
        lat_sector <= pick_sector;
        err_flag   <= 1'b0;
      end else if (reject_fire || tmo_fire) begin
        err_flag   <= 1'b1;
      end
      if (grant_fire)             irq <= 1'b1;
      else if (tmo_fire || iack)  irq <= 1'b0;
    end
  end

  // MCU byte-serial command decoder and translated-sector load
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd       <= '0;
      byte_cnt  <= '0;
      go_done   <= 1'b0;
      data_out  <= '0;
      sd_sector <= '0;
    end else if (cmd_stb) begin
      cmd      <= data_in;
      byte_cnt <= '0;
      go_done  <= 1'b0;
      data_out <= {st_bits, 3'b000, irq, sd_rbusy, any_pend};
    end else if (dat_stb) begin
      if (byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
      case (cmd)
        CMD_STATUS: begin
          case (byte_cnt)
            3'd0:    data_out <= {state == PENDING, dir, 3'b000, grant};
            3'd1:    data_out <= lat_sector[31:24];
            3'd2:    data_out <= lat_sector[23:16];
            3'd3:    data_out <= lat_sector[15:8];
            3'd4:    data_out <= lat_sector[7:0];
            default: data_out <= 8'h00;
          endcase
        end
        CMD_GO: begin
          if (byte_cnt < 3'd4) begin
            if (state == PENDING) begin
              sd_sector <= {sd_sector[SECTOR_W-9:0], data_in};
              data_out  <= {7'd0, eng_busy};
              if (byte_cnt == 3'd3) go_done <= 1'b1;
            end else begin
              data_out  <= 8'hff;
            end
          end else begin
            data_out <= go_done ? {7'd0, eng_busy} : 8'hff;
          end
        end
        default: data_out <= 8'h00;
      endcase
    end
  end

  // Engine start strobes, held until the engine reports done
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sd_rstart <= 1'b0;
      sd_wstart <= 1'b0;
    end else if (go_fire) begin
      sd_rstart <= ~dir;
      sd_wstart <= dir;
    end else if ((state == XFER) && sd_rdone) begin
      sd_rstart <= 1'b0;
      sd_wstart <= 1'b0;
    end
  end

  // Per-channel status and engine data routing to the granted channel
  always_comb begin
    gnt_oh    = '0;
    sd_inbyte = 8'h00;
    for (int k = 0; k < CHANNELS; k++) begin
      gnt_oh[k] = (grant == 3'(k));
      if ((state != IDLE) && (grant == 3'(k))) sd_inbyte = ch_inbyte[k*8 +: 8];
    end
    ch_busy  = pend_r | pend_w | ((state != IDLE) ? gnt_oh : '0);
    ch_done  = (state == FINISH) ? gnt_oh : '0;
    ch_err   = ((state == FINISH) && err_flag) ? gnt_oh : '0;
    ch_outen = ((state == XFER) && sd_outen && !dir) ? gnt_oh : '0;
  end

endmodule
